// File: rtl/skinny_sbox_layer_ctrl.sv
// Purpose: sequences all NIBBLES nibbles of a shared state through one shared, clock-gated masked Skinny S-box.
// Latency: LATENCY+2 cycles per nibble; done pulses NIBBLES*(LATENCY+2)+1 cycles after start is accepted.
// Backpressure: holds in LOAD while fresh_valid=0; start is ignored unless idle. Optional: SBOX_CTRL_SYNCH_CHECK_EN.
module skinny_sbox_layer_ctrl #(
    parameter int  SECURITY_ORDER = 3,
    parameter int  LATENCY        = 11,
    parameter int  NIBBLES        = 16,
    localparam int SHARES         = SECURITY_ORDER + 1,
    localparam int SW             = 4 * NIBBLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SW*SHARES-1:0] state_in,
    output logic                 busy,
    output logic                 done,
    output logic [SW*SHARES-1:0] state_out,
    output logic                 err,
    output logic [4*SHARES-1:0]  sbox_in,
    output logic                 sbox_rst,
    input  logic [4*SHARES-1:0]  sbox_out,
    input  logic                 sbox_synch,
    input  logic                 fresh_valid,
    output logic                 prng_en
);

    localparam int IW = 4;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        FIN   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW*SHARES-1:0] in_q, in_d;
    logic [SW*SHARES-1:0] res_q, res_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sbox_rst_q, sbox_rst_d;
    logic                 prng_en_q, prng_en_d;

    // Next-state logic; results overwrite the consumed input nibble in place and
    // the whole buffer is published to state_out only when the last nibble lands.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = state_in;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (fresh_valid) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STORE: begin
                for (int k = 0; k < SHARES; k++) begin
                    in_d[SW*k + 4*int'(idx_q) +: 4] = sbox_out[4*k +: 4];
                end
                if (idx_q == IDX_LAST) begin
                    res_d   = in_d;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = LOAD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d     = (state_d == LOAD) || (state_d == WAIT) || (state_d == STORE);
        done_d     = (state_d == FIN);
        sbox_rst_d = (state_d != WAIT);
        prng_en_d  = (state_d == WAIT);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            in_q       <= '0;
            res_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sbox_rst_q <= 1'b1;
            prng_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sbox_rst_q <= sbox_rst_d;
            prng_en_q  <= prng_en_d;
        end
    end

    // Present the current nibble of every share; zero outside a layer so no stale shares linger.
    always_comb begin
        sbox_in = '0;
        if ((state_q == LOAD) || (state_q == WAIT) || (state_q == STORE)) begin
            for (int k = 0; k < SHARES; k++) begin
                sbox_in[4*k +: 4] = in_q[SW*k + 4*int'(idx_q) +: 4];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = res_q;
    assign sbox_rst  = sbox_rst_q;
    assign prng_en   = prng_en_q;

`ifdef SBOX_CTRL_SYNCH_CHECK_EN
    logic err_q, err_d;

    // Synch must be high exactly in the last WAIT cycle; any other pattern is latched until reset.
    always_comb begin
        err_d = err_q;
        if ((state_q == WAIT) && (sbox_synch != (cnt_q == CNT_LAST))) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_synch;
    assign unused_synch = sbox_synch;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Purpose: randomized self-checking bench for skinny_sbox_layer_ctrl with a behavioural masked S-box.
// Latency: expects done NIBBLES*(LATENCY+2)+1 cycles after start plus one cycle per fresh stall.
// Backpressure: drives fresh_valid low for a window to exercise the LOAD stall.
module tb_skinny_sbox_layer_ctrl;

    localparam int LAT = 11;
    localparam int SH  = 4;
    localparam int W   = 64 * SH;

`ifdef SBOX_CTRL_SYNCH_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  state_in = '0;
    logic          busy, done, err, sbox_rst, prng_en, sbox_synch;
    logic [W-1:0]  state_out;
    logic [4*SH-1:0] sbox_in, sbox_out;
    logic          fresh_valid = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    bit early_mode = 1'b0;
    bit rand_masks = 1'b0;

    skinny_sbox_layer_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_in    (state_in),
        .busy        (busy),
        .done        (done),
        .state_out   (state_out),
        .err         (err),
        .sbox_in     (sbox_in),
        .sbox_rst    (sbox_rst),
        .sbox_out    (sbox_out),
        .sbox_synch  (sbox_synch),
        .fresh_valid (fresh_valid),
        .prng_en     (prng_en)
    );

    always #5 clk = ~clk;

    // ---------------- reference functions ----------------
    function automatic logic [3:0] sb4(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hF7E4D583B2A1096C;
        return t[4*x +: 4];
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sb4(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] xor_shares(input logic [W-1:0] s);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < SH; k++) v = v ^ s[64*k +: 64];
        return v;
    endfunction

    function automatic logic [W-1:0] mk_shares(input logic [63:0] v);
        logic [63:0] a, b, c;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        return {v ^ a ^ b ^ c, c, b, a};
    endfunction

    // Masked S-box behaviour: unmask, substitute, remask (fresh masks or share 0 only).
    function automatic logic [4*SH-1:0] share_out(input logic [4*SH-1:0] in, input bit rnd);
        logic [3:0]      x;
        logic [4*SH-1:0] o;
        x = '0;
        for (int k = 0; k < SH; k++) x = x ^ in[4*k +: 4];
        o = '0;
        if (rnd) o[4*SH-1:4] = (4*SH-4)'($urandom);
        o[3:0] = sb4(x) ^ o[7:4] ^ o[11:8] ^ o[15:12];
        return o;
    endfunction

    // ---------------- S-box model ----------------
    int              m_cnt = 0;
    int              m_nib = 0;
    logic [4*SH-1:0] sbox_out_r = '0;

    // Counts cycles since release, scrambles the output early and publishes the result on its last cycle.
    always @(posedge clk) begin
        if (sbox_rst) m_cnt <= 0;
        else          m_cnt <= m_cnt + 1;
        if (!busy) m_nib <= 0;
        if (!sbox_rst && m_cnt == 0) sbox_out_r <= (4*SH)'($urandom);
        if (!sbox_rst && m_cnt == LAT - 1) begin
            sbox_out_r <= share_out(sbox_in, rand_masks);
            if (busy) m_nib <= m_nib + 1;
        end
    end

    assign sbox_out   = sbox_out_r;
    assign sbox_synch = !sbox_rst && (m_cnt == ((early_mode && m_nib == 3) ? LAT - 2 : LAT - 1));

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one layer; cycle k=1 is the first cycle after the start edge.
    task automatic run_layer(input logic [W-1:0] s, input int stall_at, input int rst_at,
                             input int ss_at, input logic [W-1:0] s2,
                             output int done_cyc, output int prng_cnt, output int pulses,
                             output logic [W-1:0] mid_out);
        int              k;
        logic [4*SH-1:0] nib0;
        nib0 = '0;
        for (int j = 0; j < SH; j++) nib0[4*j +: 4] = s[64*j +: 4];
        @(negedge clk);
        state_in = s;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        done_cyc = -1;
        prng_cnt = 0;
        pulses   = 0;
        mid_out  = '0;
        forever begin
            if (prng_en) prng_cnt++;
            if (done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    check_eq("busy_at_done", busy, 0);
                    check_eq("sbox_in_fin", sbox_in, 0);
                end
            end
            if (k == 1) begin
                check_eq("busy_first", busy, 1);
                check_eq("sbox_in_nib0", sbox_in, nib0);
                check_eq("sbox_rst_load", sbox_rst, 1);
            end
            if (k == 2 && stall_at != 1) check_eq("prng_en_wait", prng_en, 1);
            if (k == 100) mid_out = state_out;
            if (early_mode && k == 51) check_eq("err_after_early", err, ERR_EXP);
            if (rst_at > 0 && k == rst_at + 1) begin
                check_eq("rst_busy", busy, 0);
                check_eq("rst_state_out", state_out, 0);
                check_eq("rst_sbox_rst", sbox_rst, 1);
                check_eq("rst_prng_en", prng_en, 0);
                check_eq("rst_sbox_in", sbox_in, 0);
                check_eq("rst_done", done, 0);
                rst = 1'b1;
                break;
            end
            fresh_valid = !(stall_at > 0 && k >= stall_at && k < stall_at + 5);
            if (rst_at > 0 && k == rst_at) rst = 1'b0;
            if (ss_at > 0) begin
                start    = (k == ss_at);
                state_in = (k == ss_at) ? s2 : s;
            end
            if (done_cyc >= 0 && k >= done_cyc + 3) break;
            if (k >= 600) break;
            @(negedge clk);
            k++;
        end
        fresh_valid = 1'b1;
        start       = 1'b0;
        if (rst_at == 0) check_eq("layer_completed", done_cyc >= 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] s, s2, prev;
        logic [63:0]  tgt;
        int           dc, pc, pl;
        logic [W-1:0] mid;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_state_out", state_out, 0);
        check_eq("reset_sbox_rst", sbox_rst, 1);
        check_eq("reset_prng_en", prng_en, 0);
        check_eq("reset_sbox_in", sbox_in, 0);
        rst = 1'b1;

        // Single unmasked-style layer: exact share contents known.
        rand_masks = 1'b0;
        s = {192'b0, 64'h0123456789ABCDEF};
        run_layer(s, 0, 0, 0, '0, dc, pc, pl, mid);
        check_eq("t1_done_cycle", dc, 209);
        check_eq("t1_state_out", state_out, {192'b0, sbox64(64'h0123456789ABCDEF)});
        check_eq("t1_prng_cnt", pc, 176);
        check_eq("t1_pulses", pl, 1);
        check_eq("t1_mid_out", mid, 0);
        prev = state_out;

        // Random shares with fresh output masks.
        rand_masks = 1'b1;
        tgt = 64'hFEDCBA9876543210;
        s = mk_shares(tgt);
        run_layer(s, 0, 0, 0, '0, dc, pc, pl, mid);
        check_eq("t2_done_cycle", dc, 209);
        check_eq("t2_xor_out", xor_shares(state_out), sbox64(tgt));
        check_eq("t2_err", err, 0);
        check_eq("t2_mid_out_held", mid, prev);

        // Fresh-randomness stall during LOAD of nibble 7.
        s = mk_shares(tgt);
        run_layer(s, 1 + 13 * 7, 0, 0, '0, dc, pc, pl, mid);
        check_eq("t3_done_cycle", dc, 214);
        check_eq("t3_xor_out", xor_shares(state_out), sbox64(tgt));
        check_eq("t3_prng_cnt", pc, 176);

        // Second start while busy is ignored.
        tgt = {$urandom, $urandom};
        s  = mk_shares(tgt);
        s2 = mk_shares(~tgt);
        run_layer(s, 0, 0, 50, s2, dc, pc, pl, mid);
        check_eq("t4_done_cycle", dc, 209);
        check_eq("t4_xor_out", xor_shares(state_out), sbox64(tgt));
        check_eq("t4_pulses", pl, 1);

        // Reset mid-layer, then a clean layer.
        s = mk_shares({$urandom, $urandom});
        run_layer(s, 0, 100, 0, '0, dc, pc, pl, mid);
        tgt = {$urandom, $urandom};
        s = mk_shares(tgt);
        run_layer(s, 0, 0, 0, '0, dc, pc, pl, mid);
        check_eq("t5_done_cycle", dc, 209);
        check_eq("t5_xor_out", xor_shares(state_out), sbox64(tgt));

        // Early Synch on nibble 3.
        early_mode = 1'b1;
        tgt = {$urandom, $urandom};
        s = mk_shares(tgt);
        run_layer(s, 0, 0, 0, '0, dc, pc, pl, mid);
        check_eq("t6_done_cycle", dc, 209);
        check_eq("t6_err_held", err, ERR_EXP);
        check_eq("t6_xor_out", xor_shares(state_out), sbox64(tgt));
        early_mode = 1'b0;

        // Reset clears the sticky flag and the result.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("final_rst_err", err, 0);
        check_eq("final_rst_state_out", state_out, 0);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/skinny_sbox_layer_ctrl.md
# skinny_sbox_layer_ctrl

Sequencer that applies the masked Skinny 4-bit S-box to all 16 nibbles of a 64-bit shared state using one shared, clock-gated HPC2 S-box instance. It sits between the round datapath and the S-box. It serialises nibbles, holds each nibble's shares stable for the S-box latency, restarts the S-box gating controller per nibble, enables the fresh-randomness source, and collects the shared results.

## Interface
- SECURITY_ORDER, 3, masking order d; SHARES = d+1
- LATENCY, 11, S-box cycles from gating-controller release to Synch
- NIBBLES, 16, nibbles per state
- clk  in  1  system clock; also clocks the S-box gadgets
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- state_in  in  64*SHARES  share k in bits [64k+63:64k]; nibble i of each share in bits [4i+3:4i]
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse when state_out becomes valid
- state_out  out  64*SHARES  result, same packing as state_in
- err  out  1  sticky Synch-mismatch flag (see Configuration)
- sbox_in  out  4*SHARES  {s3..s0} nibble shares to the S-box
- sbox_rst  out  1  active-high restart of the S-box gating controller
- sbox_out  in  4*SHARES  S-box output shares
- sbox_synch  in  1  S-box Synch
- fresh_valid  in  1  PRNG has fresh randomness available
- prng_en  out  1  advance the PRNG this cycle

## Operation
- FSM states: IDLE, LOAD, WAIT, STORE, FIN.
- **IDLE**
  - sbox_rst=1.
  - On start=1: latch state_in into an input buffer, set idx=0, go to LOAD.
- **LOAD**
  - Drive nibble idx of every share on sbox_in; sbox_rst=1.
  - If fresh_valid=1: go to WAIT with wait counter c=0. Otherwise stay in LOAD.
- **WAIT**
  - sbox_rst=0, prng_en=1, sbox_in held.
  - c increments each cycle; at c==LATENCY-1, go to STORE.
- **STORE**
  - Write sbox_out into nibble idx of every result share; sbox_rst=1; prng_en=0.
  - If idx==NIBBLES-1, go to FIN. Otherwise idx+1 and go to LOAD.
- **FIN**
  - done=1 for one cycle; go to IDLE.
  - state_out keeps its value until the next completed layer.
- sbox_in is 0 in IDLE/FIN, so no stale shares stay on the S-box inputs.
- Shares are never combined. Every share path is independent (no XOR across shares).
- start while busy is ignored. No queuing.
- idx is 4 bits and never wraps past NIBBLES-1.
- **Reset (rst=0 at any edge, including mid-layer):**
  - Next state IDLE; busy=0, done=0, err=0, prng_en=0, sbox_rst=1, sbox_in=0.
  - Result and input buffers = 0, so state_out=0.
  - A partially processed layer is discarded.

## Timing
- start accepted at edge t → busy=1 from cycle t+1.
- Per nibble, when fresh_valid is continuously high: 1 LOAD + LATENCY WAIT + 1 STORE = LATENCY+2 cycles (13 by default).
- Full layer: 16·13 = 208 cycles. done=1 in cycle t+209; busy falls the same cycle.
- Each LOAD cycle with fresh_valid=0 adds exactly one cycle.
- sbox_synch is expected high in the WAIT cycle with c==LATENCY-1. sbox_out is sampled at the STORE edge.
- prng_en is high for exactly LATENCY cycles per nibble.
- Outputs are registered, except sbox_in, which is driven from registered idx and buffers.

## Configuration
- SBOX_CTRL_SYNCH_CHECK_EN defined:
  - In WAIT, sbox_synch=1 with c≠LATENCY-1 sets err.
  - sbox_synch=0 with c==LATENCY-1 sets err.
  - err stays set until reset. The layer still completes normally.
- Undefined: sbox_synch is ignored, err is tied to 0, and no checker logic is built.

## Test plan
- Reset then single layer:
  - Stimulus: state_in shares s0=0x0123456789ABCDEF, s1=s2=s3=0, start pulse, fresh_valid=1.
  - Required: done at cycle 209 after start; s0 of state_out = Skinny-64 S-box applied nibble-wise; other shares 0.
- Random shares:
  - Stimulus: random shares with XOR = 0xFEDCBA9876543210.
  - Required: XOR of state_out shares = nibble-wise S-box of 0xFEDCBA9876543210; err=0.
- Fresh stall:
  - Stimulus: fresh_valid=0 for 5 cycles during the LOAD of nibble 7.
  - Required: done at 214; result unchanged; prng_en count = 176.
- Reset mid-layer:
  - Stimulus: rst=0 at cycle 100.
  - Required: next cycle busy=0, state_out=0, sbox_rst=1. A new start then completes normally in 209 cycles.
- Start while busy:
  - Stimulus: second start at cycle 50 with different state_in.
  - Required: ignored; result is from the first state_in; one done pulse.
- With SBOX_CTRL_SYNCH_CHECK_EN:
  - Stimulus: S-box model raises sbox_synch one cycle early on nibble 3.
  - Required: err=1 from the next cycle, held through done.
  - Without the macro, same stimulus → err=0.
